// File: rtl/gbt_tx_if.sv
// gbt_tx_if -- bus bundle between the frame source and gbt_tx_sequencer.
//
// Signals:
//   data_i       user frame, 14 lanes x 8 bits, lane n = data_i[n*8+:8]
//   data_valid_i user frame valid
//   data_ready_o sequencer accepts data_i this cycle
//   test_mode_i  request PRBS test pattern
//   data_o       frame to the 14 elink serializers
//   state_o      current sequencer state
//   link_up_o    high in LINK_UP or TEST
//   fill_cnt_o   idle frames inserted while in LINK_UP, saturating
//
// master: the frame source / observer side. slave: the sequencer.
`timescale 1ns/1ps
interface gbt_tx_if;
  logic [111:0] data_i;
  logic         data_valid_i;
  logic         data_ready_o;
  logic         test_mode_i;
  logic [111:0] data_o;
  logic [1:0]   state_o;
  logic         link_up_o;
  logic [15:0]  fill_cnt_o;

  modport master (
    output data_i, data_valid_i, test_mode_i,
    input  data_ready_o, data_o, state_o, link_up_o, fill_cnt_o
  );

  modport slave (
    input  data_i, data_valid_i, test_mode_i,
    output data_ready_o, data_o, state_o, link_up_o, fill_cnt_o
  );
endinterface

// File: rtl/gbt_tx_sequencer.sv
// gbt_tx_sequencer -- GBT transmit link bring-up sequencer.
//
// Waits for the GBT transmitter and serializer clocking, sends TRAIN_CYCLES
// training frames, then forwards user frames with one cycle of latency and
// fills idle cycles with IDLE_BYTE on every lane.
//
// Ports:
//   clock      40 MHz frame clock (serializer parallel side)
//   reset_n    asynchronous active-low reset
//   gbt_txrdy  GBT transmitter ready, asynchronous to clock
//   link_lock  serializer locked and out of reset, synchronous to clock
//   bus        gbt_tx_if.slave: user frame handshake, serializer frame,
//              state, link-up flag and idle-fill counter
//
// Build option: define GBT_TX_PRBS_EN to include the PRBS7 test-pattern
// generator and the TEST state. Without it test_mode_i is ignored.
`timescale 1ns/1ps
module gbt_tx_sequencer #(
  parameter logic [15:0] TRAIN_CYCLES = 16'd256,
  parameter logic [7:0]  TRAIN_BYTE   = 8'hF0,
  parameter logic [7:0]  IDLE_BYTE    = 8'hBC
) (
  input  logic    clock,
  input  logic    reset_n,
  input  logic    gbt_txrdy,
  input  logic    link_lock,
  gbt_tx_if.slave bus
);

  typedef enum logic [1:0] {
    ST_WAIT    = 2'd0,
    ST_TRAIN   = 2'd1,
    ST_LINK_UP = 2'd2,
    ST_TEST    = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic          txrdy_meta_q;
  logic          txrdy_s_q;
  logic [15:0]   train_cnt_q, train_cnt_d;
  logic [111:0]  data_q, data_d;
  logic          link_up_q, link_up_d;
  logic [15:0]   fill_cnt_q, fill_cnt_d;
  logic          test_req;
  logic          data_ready;
  logic          accept;

`ifdef GBT_TX_PRBS_EN
  logic [6:0]    lfsr_q, lfsr_d;
  logic [6:0]    prbs_seed;
  logic [14:0]   prbs_step;

  // Eight steps of x^7+x^6+1; returns {next_state, byte} with the first
  // generated bit landing in byte bit 7.
  function automatic logic [14:0] prbs7_step8(input logic [6:0] seed);
    logic [6:0] s;
    logic [7:0] b;
    logic       nb;
    s = seed;
    b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      nb = s[6] ^ s[5];
      s  = {s[5:0], nb};
      b  = {b[6:0], nb};
    end
    return {s, b};
  endfunction

  assign test_req   = bus.test_mode_i;
  assign data_ready = (state_q == ST_LINK_UP) & txrdy_s_q & link_lock & ~bus.test_mode_i;
`else
  logic unused_test_mode;
  assign unused_test_mode = bus.test_mode_i;
  assign test_req   = 1'b0;
  assign data_ready = (state_q == ST_LINK_UP) & txrdy_s_q & link_lock;
`endif

  assign accept = bus.data_valid_i & data_ready;

  always_comb begin
    state_d     = state_q;
    train_cnt_d = train_cnt_q;
    fill_cnt_d  = fill_cnt_q;
    data_d      = {14{IDLE_BYTE}};
`ifdef GBT_TX_PRBS_EN
    lfsr_d      = lfsr_q;
    prbs_seed   = lfsr_q;
    prbs_step   = 15'h0;
`endif

    // Loss of transmitter ready or serializer lock overrides everything.
    if (!txrdy_s_q || !link_lock) begin
      state_d = ST_WAIT;
    end else begin
      case (state_q)
        ST_WAIT: begin
          state_d     = ST_TRAIN;
          train_cnt_d = 16'd0;
        end
        ST_TRAIN: begin
          // The entry edge already emitted frame 1, so the count tops out
          // at TRAIN_CYCLES-1.
          if (train_cnt_q == TRAIN_CYCLES - 16'd1) state_d = ST_LINK_UP;
          else train_cnt_d = train_cnt_q + 16'd1;
        end
        ST_LINK_UP: if (test_req)  state_d = ST_TEST;
        ST_TEST:    if (!test_req) state_d = ST_LINK_UP;
        default:    state_d = ST_WAIT;
      endcase
    end

    // Output frame follows the state being entered so data_o and state_o
    // update on the same edge.
    if (state_d == ST_TRAIN) begin
      data_d = {14{TRAIN_BYTE}};
    end else if (state_d == ST_LINK_UP) begin
      if (accept) data_d = bus.data_i;
    end
`ifdef GBT_TX_PRBS_EN
    else if (state_d == ST_TEST) begin
      prbs_seed = (state_q == ST_TEST) ? lfsr_q : 7'h7F;
      prbs_step = prbs7_step8(prbs_seed);
      lfsr_d    = prbs_step[14:8];
      data_d    = {14{prbs_step[7:0]}};
    end
`endif

    // Only idle frames sent while staying in LINK_UP are counted.
    if (state_q == ST_LINK_UP && state_d == ST_LINK_UP && !accept &&
        fill_cnt_q != 16'hFFFF) begin
      fill_cnt_d = fill_cnt_q + 16'd1;
    end

    link_up_d = (state_d == ST_LINK_UP) || (state_d == ST_TEST);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      txrdy_meta_q <= 1'b0;
      txrdy_s_q    <= 1'b0;
      state_q      <= ST_WAIT;
      train_cnt_q  <= 16'd0;
      data_q       <= 112'h0;
      link_up_q    <= 1'b0;
      fill_cnt_q   <= 16'd0;
`ifdef GBT_TX_PRBS_EN
      lfsr_q       <= 7'h7F;
`endif
    end else begin
      txrdy_meta_q <= gbt_txrdy;
      txrdy_s_q    <= txrdy_meta_q;
      state_q      <= state_d;
      train_cnt_q  <= train_cnt_d;
      data_q       <= data_d;
      link_up_q    <= link_up_d;
      fill_cnt_q   <= fill_cnt_d;
`ifdef GBT_TX_PRBS_EN
      lfsr_q       <= lfsr_d;
`endif
    end
  end

  assign bus.data_ready_o = data_ready;
  assign bus.data_o       = data_q;
  assign bus.state_o      = state_q;
  assign bus.link_up_o    = link_up_q;
  assign bus.fill_cnt_o   = fill_cnt_q;

endmodule

// File: tb/tb_gbt_tx_sequencer.sv
`timescale 1ns/1ps
module tb_gbt_tx_sequencer;
  localparam logic [15:0]  TRAIN_N = 16'd4;
  localparam logic [7:0]   TRAIN_B = 8'hF0;
  localparam logic [7:0]   IDLE_B  = 8'hBC;
  localparam logic [111:0] TRAIN_W = {14{TRAIN_B}};
  localparam logic [111:0] IDLE_W  = {14{IDLE_B}};

  logic clock, reset_n, gbt_txrdy, link_lock;
  gbt_tx_if bus();

  gbt_tx_sequencer #(
    .TRAIN_CYCLES(TRAIN_N), .TRAIN_BYTE(TRAIN_B), .IDLE_BYTE(IDLE_B)
  ) dut (
    .clock(clock), .reset_n(reset_n), .gbt_txrdy(gbt_txrdy),
    .link_lock(link_lock), .bus(bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int m_fill   = 0;   // reference idle-fill count

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [111:0] obs, input logic [111:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic bump();
    if (m_fill < 65535) m_fill++;
  endtask

  function automatic logic [111:0] rand112();
    logic [127:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom()};
    return r[111:0];
  endfunction

  // Expected after raising gbt_txrdy with state WAIT and synchronizer low:
  // two WAIT edges (synchronizer), four training frames, then LINK_UP.
  task automatic bring_up(input string tag);
    int exp_st [7] = '{0, 0, 1, 1, 1, 1, 2};
    gbt_txrdy = 1'b1;
    for (int k = 0; k < 7; k++) begin
      step();
      check_eq($sformatf("%s_state%0d", tag, k), bus.state_o, exp_st[k]);
      check_eq($sformatf("%s_data%0d", tag, k), bus.data_o, (exp_st[k] == 1) ? TRAIN_W : IDLE_W);
    end
    check_eq({tag, "_linkup"}, bus.link_up_o, 1'b1);
    check_eq({tag, "_fill"}, bus.fill_cnt_o, m_fill);
  endtask

  // One steady LINK_UP cycle: offered frame goes straight out or an idle
  // frame is inserted and counted.
  task automatic lu_step(input string tag, input logic vld, input logic [111:0] d);
    logic [111:0] exp_w;
    bus.data_valid_i = vld;
    bus.data_i       = d;
    #1;
    check_eq({tag, "_rdy"}, bus.data_ready_o, 1'b1);
    exp_w = vld ? d : IDLE_W;
    if (!vld) bump();
    step();
    check_eq({tag, "_data"}, bus.data_o, exp_w);
    check_eq({tag, "_fill"}, bus.fill_cnt_o, m_fill);
    bus.data_valid_i = 1'b0;
  endtask

`ifdef GBT_TX_PRBS_EN
  // Reference PRBS7 bit stream from the recurrence x[n] = x[n-7] ^ x[n-6]
  // with all-ones history; gen[n] is the n-th generated bit.
  bit prbs_seq [134];
  function automatic logic [7:0] prbs_byte(input int k);
    logic [7:0] b;
    for (int j = 0; j < 8; j++) b[7-j] = prbs_seq[7 + ((8*k + j) % 127)];
    return b;
  endfunction
`endif

  initial begin
    logic [111:0] fa, fb, fc, fd;
    int exp_ab [6] = '{0, 0, 1, 1, 1, 0};
    int idle_n;

    reset_n = 1'b0;
    gbt_txrdy = 1'b0;
    link_lock = 1'b0;
    bus.data_i = '0;
    bus.data_valid_i = 1'b0;
    bus.test_mode_i = 1'b0;

    // Reset state
    repeat (3) step();
    check_eq("rst_state", bus.state_o, 2'd0);
    check_eq("rst_data", bus.data_o, 112'h0);
    check_eq("rst_linkup", bus.link_up_o, 1'b0);
    check_eq("rst_fill", bus.fill_cnt_o, 16'h0);
    check_eq("rst_rdy", bus.data_ready_o, 1'b0);

    // Bring-up
    link_lock = 1'b1;
    reset_n = 1'b1;
    bring_up("bringup");

    // Directed streaming A, B, C, gap, D
    fa = rand112(); fb = rand112(); fc = rand112(); fd = rand112();
    lu_step("strm_a", 1'b1, fa);
    lu_step("strm_b", 1'b1, fb);
    lu_step("strm_c", 1'b1, fc);
    lu_step("strm_gap", 1'b0, rand112());
    lu_step("strm_d", 1'b1, fd);

    // Random streaming
    for (int i = 0; i < 300; i++)
      lu_step($sformatf("rnd%0d", i), ($urandom_range(0, 3) != 0), rand112());

    // link_lock loss: immediate WAIT, then training restarts at once
    link_lock = 1'b0;
    #1;
    check_eq("lock_rdy", bus.data_ready_o, 1'b0);
    step();
    check_eq("lock_state", bus.state_o, 2'd0);
    check_eq("lock_linkup", bus.link_up_o, 1'b0);
    check_eq("lock_data", bus.data_o, IDLE_W);
    check_eq("lock_fill", bus.fill_cnt_o, m_fill);
    link_lock = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check_eq($sformatf("relock_state%0d", k), bus.state_o, (k < 4) ? 2'd1 : 2'd2);
      check_eq($sformatf("relock_data%0d", k), bus.data_o, (k < 4) ? TRAIN_W : IDLE_W);
      check_eq($sformatf("relock_fill%0d", k), bus.fill_cnt_o, m_fill);
    end

    // gbt_txrdy drop from LINK_UP: two more idle LINK_UP edges, then WAIT
    gbt_txrdy = 1'b0;
    step(); bump();
    step(); bump();
    step();
    check_eq("drop_state", bus.state_o, 2'd0);
    check_eq("drop_data", bus.data_o, IDLE_W);
    check_eq("drop_rdy", bus.data_ready_o, 1'b0);
    check_eq("drop_fill", bus.fill_cnt_o, m_fill);

    // Training aborted at frame 2 of 4
    gbt_txrdy = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k == 3) gbt_txrdy = 1'b0;
      step();
      check_eq($sformatf("abort_state%0d", k), bus.state_o, exp_ab[k]);
      check_eq($sformatf("abort_data%0d", k), bus.data_o, (exp_ab[k] == 1) ? TRAIN_W : IDLE_W);
    end
    check_eq("abort_rdy", bus.data_ready_o, 1'b0);
    check_eq("abort_linkup", bus.link_up_o, 1'b0);
    repeat (2) step();
    bring_up("retrain");

    // Test mode
`ifdef GBT_TX_PRBS_EN
    for (int i = 0; i < 7; i++) prbs_seq[i] = 1'b1;
    for (int i = 0; i < 127; i++) prbs_seq[i+7] = prbs_seq[i] ^ prbs_seq[i+1];
    bus.test_mode_i = 1'b1;
    #1;
    check_eq("test_rdy", bus.data_ready_o, 1'b0);
    for (int k = 0; k < 130; k++) begin
      step();
      check_eq($sformatf("prbs_state%0d", k), bus.state_o, 2'd3);
      check_eq($sformatf("prbs_data%0d", k), bus.data_o, {14{prbs_byte(k)}});
    end
    check_eq("test_linkup", bus.link_up_o, 1'b1);
    bus.test_mode_i = 1'b0;
    step();
    check_eq("test_exit_state", bus.state_o, 2'd2);
    check_eq("test_exit_data", bus.data_o, IDLE_W);
    bus.test_mode_i = 1'b1;
    step();
    check_eq("test_reseed", bus.data_o, {14{prbs_byte(0)}});
    bus.test_mode_i = 1'b0;
    step();
    check_eq("test_exit2_state", bus.state_o, 2'd2);
    check_eq("test_fill", bus.fill_cnt_o, m_fill);
`else
    bus.test_mode_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check_eq($sformatf("notest_rdy%0d", k), bus.data_ready_o, 1'b1);
      bump();
      step();
      check_eq($sformatf("notest_state%0d", k), bus.state_o, 2'd2);
      check_eq($sformatf("notest_data%0d", k), bus.data_o, IDLE_W);
    end
    bus.test_mode_i = 1'b0;
    check_eq("notest_fill", bus.fill_cnt_o, m_fill);
`endif

    // Saturation of the fill counter
    bus.data_valid_i = 1'b0;
    idle_n = 0;
    for (int i = 0; i < 70000; i++) begin
      step();
      bump();
      idle_n++;
      if ((idle_n % 10000) == 0)
        check_eq($sformatf("sat_fill%0d", idle_n), bus.fill_cnt_o, m_fill);
    end
    check_eq("sat_final", bus.fill_cnt_o, 16'hFFFF);
    check_eq("sat_state", bus.state_o, 2'd2);
    lu_step("sat_hold1", 1'b0, rand112());
    lu_step("sat_hold2", 1'b1, rand112());
    lu_step("sat_hold3", 1'b0, rand112());

    // Asynchronous reset mid-stream
    lu_step("prerst_a", 1'b1, rand112());
    bus.data_valid_i = 1'b1;
    bus.data_i = rand112();
    #2 reset_n = 1'b0;
    #1;
    check_eq("arst_data", bus.data_o, 112'h0);
    check_eq("arst_state", bus.state_o, 2'd0);
    check_eq("arst_linkup", bus.link_up_o, 1'b0);
    check_eq("arst_fill", bus.fill_cnt_o, 16'h0);
    m_fill = 0;
    bus.data_valid_i = 1'b0;
    #9 reset_n = 1'b1;
    bring_up("post_rst");
    lu_step("post_rst_a", 1'b1, rand112());
    lu_step("post_rst_idle", 1'b0, rand112());

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
